serial_add_sub: RTL

Multi-cycle, chunk-serial adder/subtractor for wide operands. Add and subtract share one adder: subtraction inverts `b` and forces carry-in to 1. Operands are processed CHUNK bits per cycle with a registered carry/borrow between chunks, so RSA-width datapaths avoid a full-width carry chain. It sits in the EX-stage ALU and is driven by the multi-cycle control through a start/done handshake.

---
 rtl/serial_add_sub.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_add_sub.sv
// Chunk-serial adder/subtractor: CHUNK bits per cycle with a registered carry between
// chunks, so the combinational carry chain never exceeds CHUNK bits.
module serial_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, bx_q, work_q, work_nxt;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [CHUNK:0]   chunk_sum;
    logic             accept, last;
    int               base;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                accept    = start;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One CHUNK-wide slice of the shared adder; subtraction already lives in bx_q and carry.
    always_comb begin
        base      = int'(idx) * CHUNK;
        chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, bx_q[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry};
        work_nxt  = work_q;
        work_nxt[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx   <= '0;
                carry <= op;
            end else if (busy) begin
                idx   <= last ? '0 : idx + 1'b1;
                carry <= chunk_sum[CHUNK];
            end
            // The last chunk is folded in directly so the flags are ready in the done cycle.
            if (last) begin
                result <= work_nxt;
                cout   <= chunk_sum[CHUNK];
                ovf    <= (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (work_nxt[WIDTH-1] != a_q[WIDTH-1]);
                zero   <= (work_nxt == '0);
            end
        end
    end

    // NOTE: operand and work registers have no reset; they are always reloaded before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= a;
            bx_q <= b ^ {WIDTH{op}};
        end else if (busy) begin
            work_q <= work_nxt;
        end
    end
endmodule
